// File: rtl/hp_inv_key_sched.sv
// Inverse AES key scheduler: walks the forward expansion backwards from its last Nk words,
// presenting one 128-bit round key per beat from round Nr down to round 0.

// One 4-byte AES S-box, computed as GF(2^8) inverse followed by the affine map.
module hardwired_sbox (
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    out_word = '0;
    for (int b = 0; b < 4; b++) out_word[8*b +: 8] = sbox_byte(in_word[8*b +: 8]);
  end

endmodule

// Key-length codes follow aeses_defines.vh: 0=128, 1=192, 2=256, 3=invalid.
module hp_inv_key_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         new_key_schedule,
  input  logic [1:0]   input_key_length,
  input  logic [0:255] last_key_words,
  input  logic         key_ready,
  output logic         valid_key_out,
  output logic [0:127] round_key_material,
  output logic [3:0]   round_index,
  output logic         busy
);

  localparam logic [1:0] KEY_128     = 2'd0;
  localparam logic [1:0] KEY_192     = 2'd1;
  localparam logic [1:0] KEY_256     = 2'd2;
  localparam logic [1:0] KEY_INVALID = 2'd3;

  typedef enum logic {IDLE, SCHED} state_t;

  state_t      state_q, state_d;
  logic [1:0]  len_q, len_d;
  logic [3:0]  r_q, r_d;
  logic [7:0]  rc_q, rc_d;
  // Window of the newest Nk words, top-aligned: win_q[7] is the youngest word and
  // win_q[4..7] is always the round key being presented.
  logic [31:0] win_q [8];
  logic [31:0] win_d [8];

  logic [1:0]  f_slot;
  logic        has_f;
  logic        use_rot;
  logic [31:0] sbox_arg;
  logic [31:0] sbox_in;
  logic [31:0] sbox_out;
  logic [31:0] f_word;
  logic        use_rcon;
  logic [31:0] older [4];
  logic        fire;

  hardwired_sbox u_sbox (
    .in_word  (sbox_in),
    .out_word (sbox_out)
  );

  // Each step rebuilds w[j-Nk] = w[j] ^ F(w[j-1]) for the four youngest j; at most one
  // of them (slot f_slot) needs the S-box.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    f_slot   = 2'd0;
    has_f    = 1'b1;
    use_rot  = 1'b1;
    sbox_arg = win_q[3];
    unique case (len_q)
      KEY_128: sbox_arg = win_q[7] ^ win_q[6];
      KEY_192: begin
        unique case (r_q % 4'd3)
          4'd0:    f_slot = 2'd0;
          4'd1:    begin f_slot = 2'd2; sbox_arg = win_q[5]; end
          default: has_f = 1'b0;
        endcase
      end
      default: use_rot = ~r_q[0];
    endcase
    sbox_in  = use_rot ? {sbox_arg[23:0], sbox_arg[31:24]} : sbox_arg;
    use_rcon = has_f & use_rot;
  end

  always_comb begin
    f_word = sbox_out ^ (use_rot ? {rc_q, 24'h000000} : 32'h0);
    for (int m = 0; m < 4; m++)
      older[m] = win_q[4+m] ^ ((has_f && (f_slot == 2'(m))) ? f_word : win_q[3+m]);
  end

  assign fire = (state_q == SCHED) && key_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    r_d     = r_q;
    rc_d    = rc_q;
    win_d   = win_q;
    unique case (state_q)
      IDLE: begin
        if (new_key_schedule && (input_key_length != KEY_INVALID)) begin
          state_d = SCHED;
          len_d   = input_key_length;
          for (int i = 0; i < 8; i++) win_d[i] = 32'h0;
          unique case (input_key_length)
            KEY_128: begin
              r_d  = 4'd10;
              rc_d = 8'h36;
              for (int k = 0; k < 4; k++) win_d[4+k] = last_key_words[32*k +: 32];
            end
            KEY_192: begin
              r_d  = 4'd12;
              rc_d = 8'h80;
              for (int k = 0; k < 6; k++) win_d[2+k] = last_key_words[32*k +: 32];
            end
            default: begin
              r_d  = 4'd14;
              rc_d = 8'h40;
              for (int k = 0; k < 8; k++) win_d[k] = last_key_words[32*k +: 32];
            end
          endcase
        end
      end
      SCHED: begin
        if (fire) begin
          if (r_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            r_d = r_q - 4'd1;
            // Rcon steps backwards: multiply by the inverse of 0x02 in GF(2^8)
            if (use_rcon) rc_d = rc_q[0] ? ((rc_q >> 1) ^ 8'h8d) : (rc_q >> 1);
            unique case (len_q)
              KEY_128: for (int m = 0; m < 4; m++) win_d[4+m] = older[m];
              KEY_192: begin
                for (int m = 0; m < 4; m++) win_d[2+m] = older[m];
                win_d[6] = win_q[2];
                win_d[7] = win_q[3];
              end
              default: begin
                for (int m = 0; m < 4; m++) win_d[m] = older[m];
                for (int m = 0; m < 4; m++) win_d[4+m] = win_q[m];
              end
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= KEY_128;
      r_q     <= 4'd0;
      rc_q    <= 8'h00;
      // NOTE: the word window is reset too; it is only eight words and keeps abort behaviour clean.
      for (int i = 0; i < 8; i++) win_q[i] <= 32'h0;
    end else begin
      // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
      len_q   <= len_d;
      r_q     <= r_d;
      rc_q    <= rc_d;
      win_q   <= win_d;
    end
  end

  assign valid_key_out      = (state_q == SCHED);
  assign busy               = (state_q != IDLE);
  assign round_index        = r_q;
  assign round_key_material = valid_key_out ? {win_q[4], win_q[5], win_q[6], win_q[7]} : 128'h0;

endmodule

// File: tb/tb_hp_inv_key_sched.sv
// Scoreboard bench for hp_inv_key_sched: a forward key-expansion model supplies the
// expected round keys, a negedge monitor pops and compares every accepted beat.
module tb_hp_inv_key_sched;

  localparam logic [1:0] KEY_128     = 2'd0;
  localparam logic [1:0] KEY_192     = 2'd1;
  localparam logic [1:0] KEY_256     = 2'd2;
  localparam logic [1:0] KEY_INVALID = 2'd3;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [255:0] KEY_A1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_A2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] LAST_A1 = {128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'h0};

  logic         clk;
  logic         rst_n;
  logic         new_key_schedule;
  logic [1:0]   input_key_length;
  logic [0:255] last_key_words;
  logic         key_ready;
  logic         valid_key_out;
  logic [0:127] round_key_material;
  logic [3:0]   round_index;
  logic         busy;

  hp_inv_key_sched dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .new_key_schedule   (new_key_schedule),
    .input_key_length   (input_key_length),
    .last_key_words     (last_key_words),
    .key_ready          (key_ready),
    .valid_key_out      (valid_key_out),
    .round_key_material (round_key_material),
    .round_index        (round_index),
    .busy               (busy)
  );

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [131:0] exp_q [$];
  logic [31:0]  mw [60];
  logic         bp_mode = 1'b0;
  logic [15:0]  lfsr = 16'hace1;

  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [131:0] got, input logic [131:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [2047:0] t;
    t = SBOX;
    return t[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int n);
    case (n)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;  5: return 8'h10;
      6: return 8'h20;  7: return 8'h40;  8: return 8'h80;  9: return 8'h1b;  default: return 8'h36;
    endcase
  endfunction

  // Forward FIPS-197 expansion; pushes round keys Nr..0 and returns the last Nk words.
  task automatic push_model(input logic [255:0] key, input int nk, output logic [0:255] lw);
    logic [31:0] t;
    int nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) mw[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = mw[i-1];
      if (i % nk == 0)               t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i/nk), 24'h0};
      else if (nk == 8 && i % 8 == 4) t = sub_word(t);
      mw[i] = mw[i-nk] ^ t;
    end
    for (int r = nr; r >= 0; r--)
      exp_q.push_back({4'(r), mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
    lw = '0;
    for (int k = 0; k < nk; k++) lw[32*k +: 32] = mw[4*(nr+1) - nk + k];
  endtask

  // key_ready driver: always 1, or an LFSR pattern during backpressure tests.
  initial begin
    key_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      key_ready = bp_mode ? lfsr[0] : 1'b1;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Monitor: pops the scoreboard on each accepted beat and checks hold-stability on stalls.
  logic         stall = 1'b0;
  logic [3:0]   hold_idx;
  logic [0:127] hold_mat;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall)
        check("stall hold", {valid_key_out, round_index, round_key_material},
              {1'b1, hold_idx, hold_mat});
      if (valid_key_out && key_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected beat: got idx=%0d mat=%h expected no beat",
                   round_index, round_key_material);
        end else begin
          check("beat", {round_index, round_key_material}, exp_q.pop_front());
        end
      end
      stall    = valid_key_out && !key_ready;
      hold_idx = round_index;
      hold_mat = round_key_material;
    end
  end

  task automatic start(input logic [1:0] len, input logic [0:255] lw);
    new_key_schedule = 1'b1;
    input_key_length = len;
    last_key_words   = lw;
    @(posedge clk);
    #1;
    new_key_schedule = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk);
      #1;
      if (!busy) done = 1'b1;
    end
    check({name, " reached idle"}, 132'(done), 132'(1));
    check({name, " all beats seen"}, 132'(exp_q.size()), 132'(0));
  endtask

  initial begin
    logic [0:255] lw;
    logic         hit;
    rst_n            = 1'b0;
    new_key_schedule = 1'b0;
    input_key_length = KEY_128;
    last_key_words   = '0;
    #12;
    check("reset valid", 132'(valid_key_out), 132'(0));
    check("reset busy", 132'(busy), 132'(0));
    check("reset idx", 132'(round_index), 132'(0));
    check("reset material", 132'(round_key_material), 132'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Invalid key length is ignored in IDLE
    start(KEY_INVALID, LAST_A1);
    check("invalid start valid", 132'(valid_key_out), 132'(0));
    check("invalid start busy", 132'(busy), 132'(0));

    // FIPS-197 A.1 with a KEY_256 start pulsed mid-schedule
    push_model(KEY_A1, 4, lw);
    start(KEY_128, LAST_A1);
    check("a1 first idx", 132'(round_index), 132'(10));
    repeat (3) @(posedge clk);
    #1;
    start(KEY_256, {KEY_A3});
    wait_idle("a1", 40);

    // Back-to-back: restart on the first idle cycle
    push_model(KEY_A1, 4, lw);
    start(KEY_128, LAST_A1);
    check("b2b valid after one gap", 132'(valid_key_out), 132'(1));
    check("b2b idx", 132'(round_index), 132'(10));
    wait_idle("b2b", 40);

    // Backpressure
    bp_mode = 1'b1;
    push_model(KEY_A1, 4, lw);
    start(KEY_128, LAST_A1);
    wait_idle("backpressure", 300);
    bp_mode = 1'b0;
    @(posedge clk);
    #1;

    // KEY_192 and KEY_256 from model-derived last words
    push_model(KEY_A2, 6, lw);
    start(KEY_192, lw);
    check("a2 first idx", 132'(round_index), 132'(12));
    wait_idle("a2", 40);
    push_model(KEY_A3, 8, lw);
    start(KEY_256, lw);
    check("a3 first idx", 132'(round_index), 132'(14));
    wait_idle("a3", 40);

    // Asynchronous reset at idx 5 of a KEY_256 schedule
    push_model(KEY_A3, 8, lw);
    start(KEY_256, lw);
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(posedge clk);
      #1;
      if (valid_key_out && round_index == 4'd5) hit = 1'b1;
    end
    check("reached idx 5", 132'(hit), 132'(1));
    #2 rst_n = 1'b0;
    #1;
    check("abort valid", 132'(valid_key_out), 132'(0));
    check("abort material", 132'(round_key_material), 132'(0));
    check("abort busy", 132'(busy), 132'(0));
    check("abort idx", 132'(round_index), 132'(0));
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset idle", 132'(valid_key_out), 132'(0));
    push_model(KEY_A1, 4, lw);
    start(KEY_128, LAST_A1);
    wait_idle("after reset", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
